// File: rtl/param_buffer.sv
// Parameterised circular-buffer FIFO with registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module param_buffer #(
    parameter int ADDR_LEN  = 2,
    parameter int BIT_WIDTH = 16,
    parameter int FWFT      = 0,
    parameter int AF_LEVEL  = (2 ** ADDR_LEN) - 1,
    parameter int AE_LEVEL  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 consume,
    input  logic                 flush,
    input  logic                 clear_err,
    input  logic [BIT_WIDTH-1:0] data_in,
    output logic [BIT_WIDTH-1:0] data_out,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [ADDR_LEN:0]    count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 2 ** ADDR_LEN;
    localparam logic [ADDR_LEN:0] DEPTH_W = (ADDR_LEN + 1)'(DEPTH);
    localparam logic [ADDR_LEN:0] AF_W    = (ADDR_LEN + 1)'(AF_LEVEL);
    localparam logic [ADDR_LEN:0] AE_W    = (ADDR_LEN + 1)'(AE_LEVEL);
    localparam logic [ADDR_LEN:0] CNT_ONE = (ADDR_LEN + 1)'(1);
    localparam logic [ADDR_LEN-1:0] PTR_ONE = ADDR_LEN'(1);

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_LEN-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_LEN-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_LEN:0]    count_q, count_d;
    logic [BIT_WIDTH-1:0] dout_q, dout_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 is_empty, is_full;
    logic                 wr_en, rd_en;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_W);

    // A write into a full buffer is legal only when the head leaves on the same edge.
    assign wr_en = load && (!is_full || consume) && !flush;
    assign rd_en = consume && !is_empty && !flush;

    // NOTE: every next-state value is defaulted first so no latches are inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                dout_d   = mem[rd_ptr_q];
            end
            if (wr_en && !rd_en)      count_d = count_q + CNT_ONE;
            else if (rd_en && !wr_en) count_d = count_q - CNT_ONE;
        end

        // A fresh error in the clear cycle wins over the clear.
        ovf_d = (ovf_q && !clear_err) || (load && !consume && is_full && !flush);
        unf_d = (unf_q && !clear_err) || (consume && !load && is_empty && !flush);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // NOTE: the storage array has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = is_empty ? '0 : mem[rd_ptr_q];
        end else begin : g_registered
            assign data_out = dout_q;
        end
    endgenerate

    assign empty        = is_empty;
    assign full         = is_full;
    assign almost_empty = (count_q <= AE_W);
    assign almost_full  = (count_q >= AF_W);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
